// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sample path: capture FSM encoding, mode width and default sample width.
package dds_pkg;

  localparam int unsigned DEF_DATA_W = 12;
  localparam int unsigned MODE_W     = 4;
  localparam int unsigned MODE_MAX   = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_CAPTURE    = 2'd2,
    ST_DRAIN      = 2'd3
  } cap_state_e;

endpackage

// File: rtl/sample_capture_if.sv
// Valid/ready stream carrying drained capture words toward the host-facing sink.
interface sample_capture_if
  import dds_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/sample_ram.sv
// Capture buffer: synchronous write, asynchronous read, contents not reset.
module sample_ram #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sample_capture.sv
// Captures a block of DDS samples on sampling-controller strobes, then streams the block out
// over a valid/ready interface.
module sample_capture
  import dds_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              Fg_CLK,
  input  logic              RESET,
  input  logic              Ready,
  input  logic              Enable,
  input  logic [MODE_W-1:0] Mode,
  input  logic [DATA_W-1:0] Sample,
  input  logic              Arm,
  output logic              Busy,
  output logic [MODE_W-1:0] CapMode,
  output logic              Done,
  sample_capture_if.master  out_if
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  cap_state_e        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [MODE_W-1:0] cap_mode_q, cap_mode_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              we_c;
  logic [PTR_W-1:0]  waddr_c;
  logic [DATA_W-1:0] rdata_c;

  // Next-state, pointer and write-port logic; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cap_mode_d = cap_mode_q;
    done_d     = 1'b0;
    we_c       = 1'b0;
    waddr_c    = wr_ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Arm) begin
          state_d    = ST_WAIT_READY;
          cap_mode_d = Mode;
          wr_ptr_d   = '0;
        end
      end
      ST_WAIT_READY: begin
        if (Ready) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!Ready) begin
          state_d  = ST_WAIT_READY;
          wr_ptr_d = '0;
        end else if (Mode != cap_mode_q) begin
          // New decimation rate: restart the block, keeping a coincident strobe as word 0.
          cap_mode_d = Mode;
          we_c       = Enable;
          waddr_c    = '0;
          wr_ptr_d   = Enable ? PTR_W'(1) : '0;
        end else if (Enable) begin
          we_c     = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (wr_ptr_q == LAST_IDX) begin
            state_d  = ST_DRAIN;
            rd_ptr_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (out_if.out_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (rd_ptr_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_DRAIN);
    last_d  = valid_d && (rd_ptr_d == LAST_IDX);
  end

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cap_mode_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cap_mode_q <= cap_mode_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (Fg_CLK),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (Sample),
    .raddr (rd_ptr_q),
    .rdata (rdata_c)
  );

  assign Busy             = busy_q;
  assign CapMode          = cap_mode_q;
  assign Done             = done_q;
  assign out_if.out_data  = rdata_c;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture: expected drain words are queued from the stimulus timeline
// and popped as the sink accepts them.
module tb_sample_capture;
  import dds_pkg::*;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              ready;
  logic              enable;
  logic              arm;
  logic [MODE_W-1:0] mode;
  logic [DATA_W-1:0] sample;
  logic              busy;
  logic [MODE_W-1:0] cap_mode;
  logic              done;

  sample_capture_if #(.DATA_W(DATA_W)) bus ();

  sample_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .Fg_CLK  (clk),
    .RESET   (rst),
    .Ready   (ready),
    .Enable  (enable),
    .Mode    (mode),
    .Sample  (sample),
    .Arm     (arm),
    .Busy    (busy),
    .CapMode (cap_mode),
    .Done    (done),
    .out_if  (bus.master)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; the next edge is edge_n + 1.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_pass = 0;
  int n_chk  = 0;
  int exp_q[$];

  function automatic int period(input int m);
    int p;
    p = 1;
    if (m > int'(MODE_MAX)) return 1;
    for (int i = 0; i < m; i++) p = p * 10;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive the per-cycle stream inputs for the coming edge, then move to the next falling edge.
  task automatic step();
    sample = DATA_W'(edge_n + 1);
    enable = (((edge_n + 1) % period(int'(mode))) == 0);
    @(negedge clk);
  endtask

  task automatic push_block(input int first_edge, input int m, output int last_edge);
    int n;
    int cnt;
    n   = first_edge;
    cnt = 0;
    last_edge = first_edge;
    while (cnt < int'(DEPTH)) begin
      if ((n % period(m)) == 0) begin
        exp_q.push_back(n % (1 << DATA_W));
        last_edge = n;
        cnt++;
      end
      n++;
    end
  endtask

  task automatic wait_fill(input int last_edge);
    int g;
    g = 0;
    while (!bus.out_valid && g < 20000) begin
      step();
      g++;
    end
    chk("fill_edge", 32'(edge_n), 32'(last_edge));
  endtask

  task automatic drain(input int n, input bit rnd, input bit arm_pulse);
    int got;
    int g;
    int e;
    bit stalled;
    logic [DATA_W-1:0] pd;
    logic pl;
    got = 0;
    g = 0;
    stalled = 1'b0;
    pd = '0;
    pl = 1'b0;
    while (got < n && g < 4000) begin
      g++;
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      if (stalled) begin
        chk("hold_data", 32'(bus.out_data), 32'(pd));
        chk("hold_last", 32'(bus.out_last), 32'(pl));
      end
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      arm = arm_pulse && ((g % 7) == 3);
      if (bus.out_ready && bus.out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("out_data", 32'(bus.out_data), 32'(e));
        chk("out_last", 32'(bus.out_last), 32'(exp_q.size() == 0));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = bus.out_valid;
        pd = bus.out_data;
        pl = bus.out_last;
      end
      step();
    end
    arm = 1'b0;
    chk("drain_count", 32'(got), 32'(n));
  endtask

  task automatic check_done(input int exp_mode, input bit arm_next);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_valid", 32'(bus.out_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_last", 32'(bus.out_last), 32'd0);
    chk("done_capmode", 32'(cap_mode), 32'(exp_mode));
    bus.out_ready = 1'b0;
    arm = arm_next;
    step();
    arm = 1'b0;
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'(arm_next));
  endtask

  initial begin
    int a;
    int m;
    int last_e;
    rst = 1'b1;
    ready = 1'b0;
    enable = 1'b0;
    arm = 1'b0;
    mode = '0;
    sample = '0;
    bus.out_ready = 1'b0;

    // Reset state
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_capmode", 32'(cap_mode), 32'd0);

    // Startup gating: Arm at edge 2, Ready rising at edge 80, Mode 0
    while (edge_n + 1 < 2) step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("arm_busy", 32'(busy), 32'd1);
    while (edge_n + 1 < 80) step();
    chk("gated_valid", 32'(bus.out_valid), 32'd0);
    ready = 1'b1;
    push_block(81, 0, last_e);
    wait_fill(last_e);
    drain(int'(DEPTH), 1'b0, 1'b0);
    check_done(0, 1'b0);

    // Decimation, Mode 1
    mode = MODE_W'(1);
    a = edge_n + 1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("dec_capmode", 32'(cap_mode), 32'd1);
    push_block(a + 2, 1, last_e);
    wait_fill(last_e);
    drain(int'(DEPTH), 1'b0, 1'b0);
    check_done(1, 1'b0);

    // Backpressure, Mode 0
    mode = '0;
    a = edge_n + 1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    push_block(a + 2, 0, last_e);
    wait_fill(last_e);
    drain(int'(DEPTH), 1'b1, 1'b0);
    check_done(0, 1'b0);

    // Arm pulses during capture and drain are ignored; Arm right after Done is taken
    a = edge_n + 1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    push_block(a + 2, 0, last_e);
    repeat (5) step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (20) step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    wait_fill(last_e);
    drain(int'(DEPTH), 1'b0, 1'b1);
    a = edge_n + 1;
    check_done(0, 1'b1);
    push_block(a + 2, 0, last_e);
    wait_fill(last_e);
    drain(int'(DEPTH), 1'b0, 1'b0);
    check_done(0, 1'b0);

    // Mode change 0 -> 2 after 20 writes, then reset in the middle of the drain
    a = edge_n + 1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    while (edge_n + 1 < a + 22) step();
    m = edge_n + 1;
    mode = MODE_W'(2);
    step();
    chk("chg_capmode", 32'(cap_mode), 32'd2);
    push_block(m, 2, last_e);
    wait_fill(last_e);
    mode = MODE_W'(3);
    drain(10, 1'b0, 1'b0);
    chk("drain_capmode_hold", 32'(cap_mode), 32'd2);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_last", 32'(bus.out_last), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_capmode", 32'(cap_mode), 32'd0);
    step();
    chk("post_rst_idle", 32'(busy), 32'd0);
    exp_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
# sample_capture

Captures a block of DDS output samples at the rate set by the sampling controller and streams them out over a valid/ready interface. It is the consumer end of the sampling controller's Ready/Enable/Mode interface. On each Enable strobe after Ready, it writes one sample into a buffer. When the buffer is full, it drains the block to a downstream sink such as a UART packer or display writer. The block sits between the DDS phase/amplitude path and the host-facing output path.

## Interface
- DATA_W, 12, sample width in bits
- DEPTH, 64, samples per capture block; power of two, 2..64
- Fg_CLK  in  1  system clock; all logic on its rising edge
- RESET  in  1  synchronous, active-high reset
- Ready  in  1  sampling controller startup-complete level; no writes while 0
- Enable  in  1  one-cycle sample strobe from the sampling controller
- Mode  in  4  current decimation mode, 0-4
- Sample  in  DATA_W  DDS sample, valid every cycle
- Arm  in  1  one-cycle request to start a capture
- Busy  out  1  high in WAIT_READY, CAPTURE and DRAIN
- CapMode  out  4  Mode value that applies to the buffered block
- out_data  out  DATA_W  drained sample
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts out_data
- out_last  out  1  current out_data is the final word of the block
- Done  out  1  one-cycle pulse after the last word is transferred

## Operation
- States:
  - IDLE: waits for Arm.
  - WAIT_READY: waits for Ready=1.
  - CAPTURE: writes samples.
  - DRAIN: streams the buffer.
- Reset:
  - State returns to IDLE; wr_ptr=0, rd_ptr=0.
  - Busy, out_valid, out_last, Done are 0; CapMode=0.
  - out_data reflects buffer[0]; its value is don't-care while out_valid=0.
  - Buffer contents are not cleared.
- IDLE:
  - Arm=1 → WAIT_READY; CapMode←Mode; wr_ptr←0.
  - Arm is ignored in every other state.
- WAIT_READY: Ready=1 → CAPTURE. A Ready that is already high still costs one cycle in WAIT_READY.
- CAPTURE:
  - Enable=1 → buffer[wr_ptr]←Sample, wr_ptr←wr_ptr+1.
  - A write at wr_ptr=DEPTH-1 → DRAIN; rd_ptr←0.
  - Enable pulses outside CAPTURE are ignored.
- Mode change during CAPTURE (Mode≠CapMode):
  - Restart: wr_ptr←0, CapMode←Mode.
  - A coincident Enable strobe's sample is written to buffer[0] and wr_ptr←1, so the new block begins with that sample.
- Ready falling during CAPTURE:
  - Abort to WAIT_READY with wr_ptr←0.
  - Ready is a level and should not fall; this behaviour is defensive.
- DRAIN:
  - out_valid=1 continuously; out_data=buffer[rd_ptr]; out_last=(rd_ptr==DEPTH-1).
  - On out_valid&out_ready, rd_ptr increments.
  - On the transfer with out_last=1 → IDLE, and Done=1 for exactly the next cycle.
  - Mode changes in DRAIN are ignored; CapMode holds.
- Pointer width: clog2(DEPTH). Pointers never wrap inside a block, because the full and last conditions end the state first.

## Timing
- Buffer read is combinational (distributed RAM); writes are synchronous.
- Arm at cycle t → Busy=1 at t+1.
- Entry to CAPTURE at t → the first Enable seen at ≥t is written.
- Last write at cycle t → out_valid=1 at t+1.
- Zero-bubble drain: with out_ready held high, one word per cycle; a block drains in DEPTH cycles.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Final transfer at t → out_valid=0, Busy=0, Done=1 at t+1.
- Arm at t+1 is accepted, so back-to-back captures have one idle cycle.
- RESET during any state → all outputs return to their reset values on the next edge.

## Structure
- Shared package dds_pkg holds:
  - State encoding: IDLE=0, WAIT_READY=1, CAPTURE=2, DRAIN=3.
  - MODE_W=4 and MODE_MAX=4.
  - Default DATA_W.
- One sub-module, sample_ram: DEPTH×DATA_W, synchronous write, asynchronous read, no reset.
- FSM, pointers and CapMode register live in sample_capture.

## Test plan
- Reset: hold RESET for 3 cycles mid-DRAIN → next cycle Busy=0, out_valid=0, out_last=0, Done=0, CapMode=0.
- Startup gating: Arm at cycle 2 with Ready rising at 80, Mode=0 (Enable every cycle), Sample=cycle count → no writes before Ready. Drain yields 64 consecutive values starting at the first post-Ready sample, out_last on word 63, Done one cycle after.
- Decimation: Mode=1 (Enable every 10th cycle), Sample=cycle count → drained words differ by 10. Capture lasts 640 cycles; CapMode=1.
- Backpressure: Mode=0, pseudo-random out_ready during DRAIN → each of the 64 words is transferred exactly once, in order. out_data and out_last are stable while out_ready=0.
- Mode change: switch Mode 0→2 after 20 writes → wr_ptr restarts and CapMode=2. All 64 drained words come from strobes after the change, spaced 100 cycles apart.
- Ignored Arm: Arm pulses during CAPTURE and DRAIN → no restart and no extra block. An Arm one cycle after Done starts a new capture.
